// File: rtl/clk_pkg.sv
// Shared mode encodings, BCD limits and the two-digit BCD increment helper
// used by the clock time-set controller.
package clk_pkg;

  typedef enum logic [1:0] {
    MODE_RUN     = 2'b00,
    MODE_SET_HR  = 2'b01,
    MODE_SET_MIN = 2'b10,
    MODE_BAD     = 2'b11
  } mode_e;

  typedef struct packed {
    logic [3:0] tens;
    logic [3:0] ones;
  } bcd2_t;

  localparam logic [7:0] MIN_MAX  = 8'h59;
  localparam logic [7:0] HR24_MAX = 8'h23;
  localparam logic [7:0] HR12_MAX = 8'h12;
  localparam logic [7:0] HR12_MIN = 8'h01;

  // Packed BCD orders like binary, so >= also pulls any stray value back in range.
  function automatic bcd2_t bcd_inc(input bcd2_t v, input logic [7:0] max_v,
                                    input logic [7:0] wrap_v);
    bcd2_t r;
    if (v >= bcd2_t'(max_v)) begin
      r = bcd2_t'(wrap_v);
    end else if (v.ones >= 4'd9) begin
      r.tens = v.tens + 4'd1;
      r.ones = 4'd0;
    end else begin
      r.tens = v.tens;
      r.ones = v.ones + 4'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/btn_repeat.sv
// Press-edge detector with hold-to-repeat: emits a one-cycle event on the
// press edge, then after REP_DLY cycles and every REP_RATE cycles while held.
module btn_repeat
  import clk_pkg::*;
#(
  parameter int unsigned REP_DLY  = 50000000,
  parameter int unsigned REP_RATE = 10000000
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic btn_i,
  input  logic en_i,
  input  logic clr_i,
  output logic ev_o
);

  localparam int unsigned MAXV = (REP_DLY > REP_RATE) ? REP_DLY : REP_RATE;
  localparam int unsigned CW   = $clog2(MAXV + 1);
  localparam logic [CW-1:0] DLY_C  = CW'(REP_DLY);
  localparam logic [CW-1:0] RATE_C = CW'(REP_RATE);
  localparam logic [CW-1:0] ONE_C  = CW'(1);

  logic          btn_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          rep_q, rep_d;
  logic          press;
  logic          strobe;

  assign press = btn_i & ~btn_q;

  // cnt_q holds cycles elapsed since the press edge (or since the last strobe).
  always_comb begin
    cnt_d  = cnt_q;
    rep_d  = rep_q;
    strobe = 1'b0;
    if (!btn_i || !en_i || clr_i) begin
      cnt_d = '0;
      rep_d = 1'b0;
    end else if (press) begin
      cnt_d = ONE_C;
      rep_d = 1'b0;
    end else if (cnt_q == (rep_q ? RATE_C : DLY_C)) begin
      strobe = 1'b1;
      cnt_d  = ONE_C;
      rep_d  = 1'b1;
    end else begin
      cnt_d = cnt_q + ONE_C;
    end
  end

  assign ev_o = en_i & (press | strobe);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      btn_q <= 1'b0;
      cnt_q <= '0;
      rep_q <= 1'b0;
    end else begin
      btn_q <= btn_i;
      cnt_q <= cnt_d;
      rep_q <= rep_d;
    end
  end

endmodule

// File: rtl/clock_set_ctrl.sv
// Hour/minute BCD time-keeping with a RUN / SET_HR / SET_MIN setting FSM,
// blink blanking of the edited field and a seconds-clear pulse on exit.
module clock_set_ctrl
  import clk_pkg::*;
#(
  parameter int unsigned H24      = 1,
  parameter int unsigned REP_DLY  = 50000000,
  parameter int unsigned REP_RATE = 10000000
) (
  input  logic       clk_in,
  input  logic       rst,
  input  logic       tick_1m,
  input  logic       tick_blink,
  input  logic       btn_mode,
  input  logic       btn_inc,
  output logic [3:0] hr_tens,
  output logic [3:0] hr_ones,
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic [1:0] mode,
  output logic       blank_hr,
  output logic       blank_min,
  output logic       sec_clr
);

  localparam logic [7:0] HR_MAX  = (H24 != 0) ? HR24_MAX : HR12_MAX;
  localparam logic [7:0] HR_WRAP = (H24 != 0) ? 8'h00 : HR12_MIN;
  localparam logic [7:0] HR_RST  = (H24 != 0) ? 8'h00 : HR12_MAX;

  mode_e state_q, state_d;
  bcd2_t hr_q, hr_d;
  bcd2_t min_q, min_d;
  logic  btn_mode_q;
  logic  phase_q, phase_d;
  logic  blank_hr_q, blank_hr_d;
  logic  blank_min_q, blank_min_d;
  logic  sec_clr_q, sec_clr_d;
  logic  mode_p;
  logic  in_set;
  logic  rep_ev;
  logic  inc_ev;

  assign mode_p = btn_mode & ~btn_mode_q;
  assign in_set = (state_q == MODE_SET_HR) || (state_q == MODE_SET_MIN);

  btn_repeat #(
    .REP_DLY (REP_DLY),
    .REP_RATE(REP_RATE)
  ) u_inc_rep (
    .clk_i (clk_in),
    .rst_ni(rst),
    .btn_i (btn_inc),
    .en_i  (in_set),
    .clr_i (mode_p),
    .ev_o  (rep_ev)
  );

  // A mode change in the same cycle swallows the increment.
  assign inc_ev = rep_ev & ~mode_p;

  always_comb begin
    state_d = state_q;
    case (state_q)
      MODE_RUN:     if (mode_p) state_d = MODE_SET_HR;
      MODE_SET_HR:  if (mode_p) state_d = MODE_SET_MIN;
      MODE_SET_MIN: if (mode_p) state_d = MODE_RUN;
      default:      state_d = MODE_RUN;
    endcase
  end

  always_comb begin
    hr_d  = hr_q;
    min_d = min_q;
    case (state_q)
      MODE_RUN: begin
        if (tick_1m) begin
          min_d = bcd_inc(min_q, MIN_MAX, 8'h00);
          if (min_q == bcd2_t'(MIN_MAX)) hr_d = bcd_inc(hr_q, HR_MAX, HR_WRAP);
        end
      end
      MODE_SET_HR:  if (inc_ev) hr_d = bcd_inc(hr_q, HR_MAX, HR_WRAP);
      MODE_SET_MIN: if (inc_ev) min_d = bcd_inc(min_q, MIN_MAX, 8'h00);
      default: ;
    endcase
  end

  // Phase restarts at 0 on any state change and on each adjustment, so the
  // edited digits are always visible right after they change.
  always_comb begin
    phase_d = phase_q;
    if ((state_d != state_q) ||
        !((state_d == MODE_SET_HR) || (state_d == MODE_SET_MIN))) begin
      phase_d = 1'b0;
    end else if (inc_ev) begin
      phase_d = 1'b0;
    end else if (tick_blink) begin
      phase_d = ~phase_q;
    end
    blank_hr_d  = (state_d == MODE_SET_HR) & phase_d;
    blank_min_d = (state_d == MODE_SET_MIN) & phase_d;
    sec_clr_d   = (state_q == MODE_SET_MIN) && (state_d == MODE_RUN);
  end

  always_ff @(posedge clk_in) begin
    if (!rst) begin
      state_q     <= MODE_RUN;
      hr_q        <= bcd2_t'(HR_RST);
      min_q       <= '0;
      btn_mode_q  <= 1'b0;
      phase_q     <= 1'b0;
      blank_hr_q  <= 1'b0;
      blank_min_q <= 1'b0;
      sec_clr_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      hr_q        <= hr_d;
      min_q       <= min_d;
      btn_mode_q  <= btn_mode;
      phase_q     <= phase_d;
      blank_hr_q  <= blank_hr_d;
      blank_min_q <= blank_min_d;
      sec_clr_q   <= sec_clr_d;
    end
  end

  assign hr_tens   = hr_q.tens;
  assign hr_ones   = hr_q.ones;
  assign min_tens  = min_q.tens;
  assign min_ones  = min_q.ones;
  assign mode      = state_q;
  assign blank_hr  = blank_hr_q;
  assign blank_min = blank_min_q;
  assign sec_clr   = sec_clr_q;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Directed bench for clock_set_ctrl: a 24-hour and a 12-hour instance share
// the same stimulus; expected times and status words are hand-computed.
module tb_clock_set_ctrl;

  logic clk_in = 1'b0;
  logic rst = 1'b0;
  logic tick_1m = 1'b0;
  logic tick_blink = 1'b0;
  logic btn_mode = 1'b0;
  logic btn_inc = 1'b0;

  logic [3:0] a_ht, a_ho, a_mt, a_mo;
  logic [3:0] b_ht, b_ho, b_mt, b_mo;
  logic [1:0] a_mode, b_mode;
  logic a_bh, a_bm, a_sc;
  logic b_bh, b_bm, b_sc;

  int unsigned npass = 0;
  int unsigned ntot = 0;

  always #5 clk_in = ~clk_in;

  clock_set_ctrl #(.H24(1), .REP_DLY(4), .REP_RATE(2)) dut24 (
    .clk_in(clk_in), .rst(rst), .tick_1m(tick_1m), .tick_blink(tick_blink),
    .btn_mode(btn_mode), .btn_inc(btn_inc),
    .hr_tens(a_ht), .hr_ones(a_ho), .min_tens(a_mt), .min_ones(a_mo),
    .mode(a_mode), .blank_hr(a_bh), .blank_min(a_bm), .sec_clr(a_sc)
  );

  clock_set_ctrl #(.H24(0), .REP_DLY(4), .REP_RATE(2)) dut12 (
    .clk_in(clk_in), .rst(rst), .tick_1m(tick_1m), .tick_blink(tick_blink),
    .btn_mode(btn_mode), .btn_inc(btn_inc),
    .hr_tens(b_ht), .hr_ones(b_ho), .min_tens(b_mt), .min_ones(b_mo),
    .mode(b_mode), .blank_hr(b_bh), .blank_min(b_bm), .sec_clr(b_sc)
  );

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  function automatic logic [15:0] st(input logic [1:0] m, input logic bh,
                                     input logic bm, input logic sc);
    return {11'd0, m, bh, bm, sc};
  endfunction

  function automatic logic [15:0] t24();
    return {a_ht, a_ho, a_mt, a_mo};
  endfunction

  function automatic logic [15:0] t12();
    return {b_ht, b_ho, b_mt, b_mo};
  endfunction

  function automatic logic [15:0] s24();
    return st(a_mode, a_bh, a_bm, a_sc);
  endfunction

  function automatic logic [15:0] s12();
    return st(b_mode, b_bh, b_bm, b_sc);
  endfunction

  task automatic ticks(input int unsigned n);
    tick_1m = 1'b1;
    repeat (n) step();
    tick_1m = 1'b0;
  endtask

  task automatic press_mode();
    btn_mode = 1'b1;
    step();
    btn_mode = 1'b0;
    step();
  endtask

  task automatic press_inc(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      btn_inc = 1'b1;
      step();
      btn_inc = 1'b0;
      step();
    end
  endtask

  task automatic blink_pulse();
    tick_blink = 1'b1;
    step();
    tick_blink = 1'b0;
  endtask

  initial begin
    step();
    step();
    chk("rst_t24", t24(), 16'h0000);
    chk("rst_t12", t12(), 16'h1200);
    chk("rst_s24", s24(), st(2'b00, 1'b0, 1'b0, 1'b0));
    chk("rst_s12", s12(), st(2'b00, 1'b0, 1'b0, 1'b0));
    rst = 1'b1;
    step();

    ticks(59);
    chk("run_0059", t24(), 16'h0059);
    chk("run12_1259", t12(), 16'h1259);
    ticks(1);
    chk("carry_0100", t24(), 16'h0100);
    chk("wrap12_0100", t12(), 16'h0100);
    ticks(59);
    chk("run_0159", t24(), 16'h0159);
    chk("run12_0159", t12(), 16'h0159);
    ticks(1320);
    chk("run_2359", t24(), 16'h2359);
    chk("run12_1159", t12(), 16'h1159);
    ticks(1);
    chk("wrap24_0000", t24(), 16'h0000);
    chk("h12_1200", t12(), 16'h1200);

    btn_mode = 1'b1;
    step();
    chk("enter_sethr", s24(), st(2'b01, 1'b0, 1'b0, 1'b0));
    btn_mode = 1'b0;
    step();
    press_inc(3);
    chk("sethr_t24", t24(), 16'h0300);
    chk("sethr_t12", t12(), 16'h0300);

    press_mode();
    chk("enter_setmin", s24(), st(2'b10, 1'b0, 1'b0, 1'b0));
    press_inc(61);
    chk("setmin_wrap24", t24(), 16'h0301);
    chk("setmin_wrap12", t12(), 16'h0301);
    tick_1m = 1'b1;
    step();
    tick_1m = 1'b0;
    chk("setmin_tick_ign", t24(), 16'h0301);

    btn_mode = 1'b1;
    step();
    chk("secclr_hi24", s24(), st(2'b00, 1'b0, 1'b0, 1'b1));
    chk("secclr_hi12", s12(), st(2'b00, 1'b0, 1'b0, 1'b1));
    btn_mode = 1'b0;
    step();
    chk("secclr_lo", s24(), st(2'b00, 1'b0, 1'b0, 1'b0));
    press_inc(1);
    chk("run_inc_ign", t24(), 16'h0301);

    press_mode();
    blink_pulse();
    chk("blank_hr_on", s24(), st(2'b01, 1'b1, 1'b0, 1'b0));
    btn_inc = 1'b1;
    step();
    chk("rep_k0", t24(), 16'h0401);
    chk("blank_hr_forced", s24(), st(2'b01, 1'b0, 1'b0, 1'b0));
    repeat (3) step();
    chk("rep_k3", t24(), 16'h0401);
    step();
    chk("rep_k4", t24(), 16'h0501);
    repeat (4) step();
    chk("rep_k8", t24(), 16'h0701);
    step();
    chk("rep_k9", t24(), 16'h0701);
    chk("rep12_k9", t12(), 16'h0701);
    btn_inc = 1'b0;
    step();
    chk("rep_release", t24(), 16'h0701);
    press_inc(1);
    chk("rep_cleared", t24(), 16'h0801);

    press_mode();
    blink_pulse();
    chk("blink1", s24(), st(2'b10, 1'b0, 1'b1, 1'b0));
    step();
    blink_pulse();
    chk("blink0", s24(), st(2'b10, 1'b0, 1'b0, 1'b0));
    step();
    blink_pulse();
    chk("blink1b", s24(), st(2'b10, 1'b0, 1'b1, 1'b0));
    btn_inc = 1'b1;
    tick_1m = 1'b1;
    tick_blink = 1'b1;
    step();
    chk("inc_tick_t24", t24(), 16'h0802);
    chk("inc_forces0", s24(), st(2'b10, 1'b0, 1'b0, 1'b0));
    btn_inc = 1'b0;
    tick_1m = 1'b0;
    tick_blink = 1'b0;
    step();

    press_mode();
    press_mode();
    chk("back_sethr", s24(), st(2'b01, 1'b0, 1'b0, 1'b0));
    btn_mode = 1'b1;
    btn_inc = 1'b1;
    step();
    chk("mode_wins_s", s24(), st(2'b10, 1'b0, 1'b0, 1'b0));
    chk("mode_wins_t", t24(), 16'h0802);
    btn_mode = 1'b0;
    btn_inc = 1'b0;
    step();
    press_inc(1);
    chk("setmin_inc", t24(), 16'h0803);
    blink_pulse();
    chk("pre_rst_blank", s24(), st(2'b10, 1'b0, 1'b1, 1'b0));

    rst = 1'b0;
    step();
    chk("midrst_t24", t24(), 16'h0000);
    chk("midrst_t12", t12(), 16'h1200);
    chk("midrst_s24", s24(), st(2'b00, 1'b0, 1'b0, 1'b0));
    chk("midrst_s12", s12(), st(2'b00, 1'b0, 1'b0, 1'b0));
    rst = 1'b1;
    step();
    chk("post_rst_t24", t24(), 16'h0000);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
